u_exe_muldiv: RTL and testbench
===============================

Name: u_exe_muldiv

Overview:
- Parametrised iterative multiply/divide execute unit implementing the RV M-extension ops.
- Sits beside the integer ALU in the execute stage.
- Accepts one op via a valid/ready handshake and computes multi-cycle.
- Returns the result with its destination register address toward the register-file write port.
- Generalises the single-cycle execute path to XLEN-wide, multi-cycle, back-pressured operation with flush.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- RF_AW, 5, register address width.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  op request from decode
- in_ready  output  1  unit can accept an op
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rd_a  input  RF_AW  destination register
- rs1_v  input  XLEN  operand 1 (rf_rs1_o)
- rs2_v  input  XLEN  operand 2 (rf_rs2_o)
- flush  input  1  kill in-flight op
- out_valid  output  1  result available
- out_ready  input  1  writeback accepts result
- rf_rd_e  output  1  register write enable
- rf_rd_a  output  RF_AW  write address
- rf_rd_i  output  XLEN  write data
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock clk; reset rstn is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, rf_rd_e=0, rf_rd_a=0, rf_rd_i=0, busy=0, in_ready=1.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. Accept on in_valid&&in_ready at edge T; latch funct3, rd_a, operands, and signs.
  - Normal path: IDLE -> CALC.
  - Divide by zero and signed overflow: IDLE -> DONE directly (out_valid at T+1).
  - CALC: counter runs XLEN cycles (T+1..T+XLEN), then -> DONE; out_valid=1 from T+XLEN+1.
  - DONE: hold out_valid, rf_rd_a, rf_rd_i stable until out_valid&&out_ready.
  - On that handshake cycle, go to IDLE; in_ready returns the following cycle. There is no same-cycle re-accept.
- rf_rd_e = out_valid && out_ready && (rf_rd_a != 0). Result is computed for x0 but never written.
- Multiply: radix-2 shift-add on magnitudes, 2*XLEN product, sign fixed at end.
  - MUL returns low XLEN bits.
  - MULH: signed x signed, high XLEN bits.
  - MULHSU: signed rs1 x unsigned rs2, high XLEN bits.
  - MULHU: unsigned x unsigned, high XLEN bits.
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient negated if operand signs differ (signed ops).
  - Remainder takes dividend sign.
- Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1_v.
- Signed overflow (DIV/REM with rs1 = -2^(XLEN-1), rs2 = -1): DIV -> rs1_v; REM -> 0.
- flush: any state -> IDLE next edge. out_valid and rf_rd_e are 0 from the next cycle. The in-flight op is discarded.
- flush together with in_valid in IDLE: the op is not accepted.
- Async reset mid-CALC or in DONE: immediate return to reset values; the op is lost.
- in_valid while busy is ignored (in_ready=0). Upstream holds the request.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: the four multiply ops use a single-cycle combinational XLEN x XLEN multiplier.
  - Multiply latency: CALC lasts 1 cycle, out_valid at T+2.
  - Divide path is unchanged.
- Undefined: multiply is iterative, out_valid at T+XLEN+1. No combinational multiplier is instantiated.

Test Plan:
- XLEN=32, MUL 7 x -3, out_ready=1 -> out_valid at T+33, rf_rd_i=0xFFFFFFEB, rf_rd_e=1 for one cycle, in_ready=1 at T+35.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF at T+1; REM 0x80000000 / -1 -> 0.
- DIV 50/5 with out_ready low 10 cycles after out_valid -> rf_rd_i=10 held stable, in_ready=0 throughout, single rf_rd_e pulse on release.
- flush at T+5 during DIV -> out_valid never rises, in_ready=1 at T+7; new MULHU 3 x 5 accepted -> 0; assert rstn low mid-CALC -> outputs 0 immediately.
- rd_a=0, MUL 2 x 2 -> out_valid=1, rf_rd_i=4, rf_rd_e stays 0. With MULDIV_FAST_MUL_EN defined -> MUL result at T+2.

Source files
------------

// File: rtl/u_exe_muldiv.sv
// u_exe_muldiv: iterative RV M-extension multiply/divide execute unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// sign applied when the result is registered. Divide-by-zero and signed
// overflow bypass the iteration and complete in one cycle.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplier for MUL*).
module u_exe_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [RF_AW-1:0] rd_a,
  input  logic [XLEN-1:0]  rs1_v,
  input  logic [XLEN-1:0]  rs2_v,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rf_rd_e,
  output logic [RF_AW-1:0] rf_rd_a,
  output logic [XLEN-1:0]  rf_rd_i,
  output logic             busy
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [2:0]      op;
  logic            neg_res;
  logic            neg_rem;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mag_b;
  logic [CW-1:0]   cnt;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  logic [XLEN:0]   msum, dshift, ddiff;
  logic [XLEN-1:0] nxt_hi, nxt_lo, q_res, r_res, result;
  logic [PW-1:0]   prod, prod_s;
  logic            last;

  // Operand decode at accept time: signedness, magnitudes, early-out cases
  always_comb begin
    a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_sgn & rs1_v[XLEN-1];
    b_neg    = b_sgn & rs2_v[XLEN-1];
    a_mag    = a_neg ? XLEN'(-rs1_v) : rs1_v;
    b_mag    = b_neg ? XLEN'(-rs2_v) : rs2_v;
    div_zero = funct3[2] && (rs2_v == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs2_v == '1) &&
               (rs1_v == {1'b1, {(XLEN-1){1'b0}}});
    special  = div_zero || div_ovf;
    if (div_zero) spec_res = funct3[1] ? rs1_v : '1;
    else          spec_res = funct3[1] ? '0 : rs1_v;
  end

  // One iteration step plus signed result formation from the stepped state
  always_comb begin
    msum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    dshift = {hi, lo[XLEN-1]};
    ddiff  = dshift - {1'b0, mag_b};
    if (op[2]) begin
      if (ddiff[XLEN]) begin
        nxt_hi = dshift[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b0};
      end else begin
        nxt_hi = ddiff[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b1};
      end
    end else begin
      nxt_hi = msum[XLEN:1];
      nxt_lo = {msum[0], lo[XLEN-1:1]};
    end
    prod = {nxt_hi, nxt_lo};
    last = (cnt == LAST);
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) begin
      prod = PW'(lo) * PW'(mag_b);
      last = 1'b1;
    end
`else
`endif
    prod_s = neg_res ? PW'(-prod) : prod;
    q_res  = neg_res ? XLEN'(-nxt_lo) : nxt_lo;
    r_res  = neg_rem ? XLEN'(-nxt_hi) : nxt_hi;
    if (op[2])                result = op[1] ? r_res : q_res;
    else if (op[1:0] == 2'b00) result = prod_s[XLEN-1:0];
    else                      result = prod_s[PW-1:XLEN];
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rf_rd_a   <= '0;
      rf_rd_i   <= '0;
      op        <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      mag_b     <= '0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= (state == IDLE);
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            rf_rd_a  <= rd_a;
            op       <= funct3;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            hi       <= '0;
            lo       <= a_mag;
            mag_b    <= b_mag;
            cnt      <= '0;
            if (special) begin
              state     <= DONE;
              out_valid <= 1'b1;
              rf_rd_i   <= spec_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + CW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            rf_rd_i   <= result;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe follows the writeback handshake; x0 is never written
  assign rf_rd_e = out_valid && out_ready && (rf_rd_a != '0);

endmodule

// File: tb/tb_u_exe_muldiv.sv
// tb_u_exe_muldiv: directed and randomized checks of u_exe_muldiv against
// a plain-arithmetic reference of the RV M-extension ops.
module tb_u_exe_muldiv;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [4:0]  rd_a;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        rf_rd_e;
  logic [4:0]  rf_rd_a;
  logic [31:0] rf_rd_i;
  logic        busy;

  int n_vec;
  int n_err;

  u_exe_muldiv #(.XLEN(32), .RF_AW(5)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rd_a(rd_a), .rs1_v(rs1_v), .rs2_v(rs2_v),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a), .rf_rd_i(rf_rd_i), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expectation
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural result of an M-extension op
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    case (f)
      3'b000: begin p = 64'(sa * sb); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the accepting edge until out_valid is first seen
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 2;
`else
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  // Present one op and complete the accepting handshake
  task automatic start_op(input logic [2:0] f, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    funct3   = f;
    rd_a     = rd;
    rs1_v    = a;
    rs2_v    = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    rs1_v    = $urandom;
    rs2_v    = $urandom;
    rd_a     = 5'($urandom);
  endtask

  // Full op: latency, result, back-pressure hold, write strobe, in_ready return
  task automatic do_op(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold);
    int k;
    bit seen;
    start_op(f, rd, a, b);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (out_valid) seen = 1'b1;
    end
    chk("latency", seen ? 64'(k) : 64'hDEAD, 64'(exp_lat(f, a, b)));
    chk("busy_done", 64'(busy), 64'd1);
    chk("in_ready_done", 64'(in_ready), 64'd0);
    chk("result", 64'(rf_rd_i), 64'(exp));
    chk("rd_addr", 64'(rf_rd_a), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      chk("rd_e_held", 64'(rf_rd_e), 64'd0);
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(rf_rd_i), 64'(exp));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("rd_e", 64'(rf_rd_e), 64'(rd != 5'd0));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("rd_e_drop", 64'(rf_rd_e), 64'd0);
    chk("in_ready_lag", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_back", 64'(in_ready), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    bit          saw;
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0; in_valid = 1'b0; funct3 = '0; rd_a = '0;
    rs1_v = '0; rs2_v = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_e", 64'(rf_rd_e), 64'd0);
    chk("rst_rd_a", 64'(rf_rd_a), 64'd0);
    chk("rst_rd_i", 64'(rf_rd_i), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(3'b000, 5'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    do_op(3'b001, 5'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    do_op(3'b010, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op(3'b011, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    do_op(3'b100, 5'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    do_op(3'b110, 5'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    do_op(3'b101, 5'd7, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
    do_op(3'b110, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    do_op(3'b100, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    do_op(3'b111, 5'd10, 32'd33, 32'd0, 32'd33, 0);
    do_op(3'b100, 5'd11, 32'd50, 32'd5, 32'd10, 10);
    do_op(3'b000, 5'd0, 32'd2, 32'd2, 32'd4, 0);

    // Flush mid-divide
    start_op(3'b100, 5'd12, 32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready_lag", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("flush_ready", 64'(in_ready), 64'd1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= out_valid;
    end
    chk("flush_no_valid", 64'(saw), 64'd0);
    do_op(3'b011, 5'd13, 32'd3, 32'd5, 32'd0, 0);

    // Flush together with a request in IDLE: not accepted
    funct3 = 3'b000; rd_a = 5'd14; rs1_v = 32'd3; rs2_v = 32'd3;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= out_valid | busy;
    end
    chk("flush_idle_drop", 64'(saw), 64'd0);
    chk("flush_idle_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset mid-CALC
    start_op(3'b000, 5'd15, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("arst_calc_busy", 64'(busy), 64'd0);
    chk("arst_calc_ready", 64'(in_ready), 64'd1);
    chk("arst_calc_rd_a", 64'(rf_rd_a), 64'd0);
    chk("arst_calc_rd_i", 64'(rf_rd_i), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Asynchronous reset while holding a result
    start_op(3'b101, 5'd16, 32'd100, 32'd0);
    @(negedge clk);
    chk("done_valid", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("arst_done_valid", 64'(out_valid), 64'd0);
    chk("arst_done_rd_i", 64'(rf_rd_i), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_op(3'b000, 5'd17, 32'd6, 32'd7, 32'd42, 0);

    // Randomized ops against the reference model
    for (int i = 0; i < 120; i++) begin
      f = 3'($urandom);
      a = rand_op();
      b = rand_op();
      do_op(f, 5'($urandom), a, b, ref_model(f, a, b), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
